conf_loader: RTL
================

// Module: conf_loader
// PURPOSE
//  Frame parser and configuration scheduler between the UART receiver and the
//  DRSSTC pulse generator. Assembles received bytes into checksummed
//  write/commit frames and writes parameter values into a shadow bank. The
//  shadow bank is copied atomically into the active bank, which drives the
//  generator, only while the generator reports idle. This keeps the
//  generator from running a pulse with half-updated timing values.
// PARAMETERS
//  CONF_PAR_MAX     4        number of configuration parameters (1..255)
//  PAR_W            8        width of one parameter in bits (fixed 8: one byte per value)
//  TIMEOUT_CNT_MAX  50000    max clk cycles allowed between bytes inside a frame
// PORTS
//  clk        in   1                    system clock
//  rst        in   1                    asynchronous reset, active-high
//  byte_valid in   1                    1-cycle strobe: byte_data holds a new UART byte
//  byte_data  in   8                    received byte
//  gen_idle   in   1                    high while generator is between pulses (safe to update)
//  par_out    out  CONF_PAR_MAX*PAR_W   active bank; parameter i at [i*PAR_W +: PAR_W]
//  par_valid  out  1                    high after first successful commit
//  commit_pend out 1                    commit requested, waiting for gen_idle
//  commit_pls out  1                    1-cycle pulse in the cycle the active bank updates
//  err_cnt    out  8                    count of rejected frames, saturates at 255
//  busy       out  1                    parser not in S_HDR
// BEHAVIOUR
//  Reset (async, rst=1): shadow bank, par_out, par_valid, commit_pend, commit_pls,
//   err_cnt, busy, and timeout counter all go to 0. FSM goes to S_HDR. Any frame in
//   progress is discarded.
//  Frame: 0xA5, ADDR, DATA, CHK with CHK = 0xA5 ^ ADDR ^ DATA.
//  FSM, advancing only on byte_valid:
//   S_HDR : byte==0xA5 -> S_ADDR; any other byte is ignored silently (no error).
//   S_ADDR: latch ADDR -> S_DATA.   S_DATA: latch DATA -> S_CHK.
//   S_CHK : go to S_HDR in all cases, then act on the frame:
//     CHK mismatch                    -> err_cnt+1, frame discarded
//     ADDR < CONF_PAR_MAX             -> shadow[ADDR] <= DATA on the next clk edge
//     ADDR == 0xFF                    -> commit_pend <= 1 (DATA ignored)
//     any other ADDR                  -> err_cnt+1, frame discarded
//  Timeout: counter resets on each byte_valid and runs while state != S_HDR.
//   When it reaches TIMEOUT_CNT_MAX: go to S_HDR and err_cnt+1.
//   A byte_valid in the same cycle as the timeout is processed as a new byte from S_HDR.
//  Commit: in any cycle with commit_pend && gen_idle:
//   - par_out <= shadow
//   - par_valid <= 1
//   - commit_pend <= 0
//   - commit_pls = 1 for exactly that cycle
//   Latency is 1 cycle from gen_idle rising (with commit pending) to par_out change.
//  Simultaneous events:
//   - A shadow write and a commit in the same cycle: commit copies shadow as it
//     was before the write. The new value waits for the next commit.
//   - A commit frame completing while commit_pend=1: stays pending (requests merge).
//   - A commit frame completing with gen_idle=1 already: commit_pend sets this cycle,
//     and the copy happens on the next cycle if gen_idle is still high.
//  par_out never changes while gen_idle=0.
//  err_cnt saturates at 255 and never wraps.
// TESTING
//  1 rst, then A5 02 3C 9B, A5 FF 00 5A, gen_idle=1 -> par_out[2]=0x3C, other
//    params 0, par_valid=1, one commit_pls.
//  2 Write A5 01 10 B4 and commit while gen_idle=0 -> commit_pend=1 and par_out
//    unchanged. Raise gen_idle -> par_out[1]=0x10 one cycle later.
//  3 A5 01 10 00 (bad CHK) -> err_cnt=1, shadow unchanged. Then A5 07 11 B3
//    (CONF_PAR_MAX=4) -> err_cnt=2.
//  4 Send A5 01 and stall TIMEOUT_CNT_MAX cycles -> busy=0, err_cnt+1. Then a full
//    valid frame is accepted normally.
//  5 Send junk bytes 00 FF 5A before a valid frame -> no error, frame accepted.
//    300 bad frames -> err_cnt=255.
//  6 Assert rst mid-frame and with commit_pend=1 -> all outputs 0 immediately (async).
//    After release, the next valid frame parses from header.

Source files
------------

// File: rtl/conf_loader_if.sv
// Byte stream, generator handshake and configuration outputs of conf_loader.
// The master side feeds UART bytes and gen_idle; the slave side is the loader itself.
interface conf_loader_if #(
    parameter int CONF_PAR_MAX = 4,
    parameter int PAR_W        = 8
);
    logic                          byte_valid;
    logic [7:0]                    byte_data;
    logic                          gen_idle;
    logic [CONF_PAR_MAX*PAR_W-1:0] par_out;
    logic                          par_valid;
    logic                          commit_pend;
    logic                          commit_pls;
    logic [7:0]                    err_cnt;
    logic                          busy;

    modport master (
        output byte_valid, byte_data, gen_idle,
        input  par_out, par_valid, commit_pend, commit_pls, err_cnt, busy
    );

    modport slave (
        input  byte_valid, byte_data, gen_idle,
        output par_out, par_valid, commit_pend, commit_pls, err_cnt, busy
    );
endinterface

// File: rtl/conf_loader.sv
// Frame parser (A5, ADDR, DATA, CHK) writing a shadow parameter bank that is
// copied atomically into the active bank only while the generator is idle.
module conf_loader #(
    parameter int CONF_PAR_MAX    = 4,
    parameter int PAR_W           = 8,
    parameter int TIMEOUT_CNT_MAX = 50000
) (
    input  logic         clk,
    input  logic         rst,
    conf_loader_if.slave bus
);
    localparam int BANK_W = CONF_PAR_MAX * PAR_W;
    localparam int CNT_W  = $clog2(TIMEOUT_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CNT_MAX - 1);
    localparam logic [7:0]       HDR_BYTE    = 8'hA5;
    localparam logic [7:0]       COMMIT_ADDR = 8'hFF;
    localparam logic [7:0]       PAR_MAX_B   = 8'(CONF_PAR_MAX);

    typedef enum logic [1:0] {S_HDR, S_ADDR, S_DATA, S_CHK} state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
        return HDR_BYTE ^ addr ^ data;
    endfunction

    state_e              state_q, state_d, cur_s;
    logic [7:0]          addr_q, addr_d, data_q, data_d;
    logic [BANK_W-1:0]   shadow_q, shadow_d, par_out_q, par_out_d;
    logic                par_valid_q, par_valid_d, commit_pend_q, commit_pend_d;
    logic                commit_pls_q, commit_pls_d, busy_q, busy_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                timeout_s, frame_err_s, commit_req_s, do_commit_s;

    // Next-state: byte parsing, timeout, error counting and commit scheduling.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        shadow_d     = shadow_q;
        frame_err_s  = 1'b0;
        commit_req_s = 1'b0;
        timeout_s    = (state_q != S_HDR) && (tmo_cnt_q == TMO_LAST);
        // A byte arriving on the timeout cycle is parsed as if the frame had already been dropped.
        cur_s        = timeout_s ? S_HDR : state_q;
        do_commit_s  = commit_pend_q && bus.gen_idle;

        if (bus.byte_valid) begin
            case (cur_s)
                S_HDR: begin
                    if (bus.byte_data == HDR_BYTE) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = bus.byte_data;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    data_d  = bus.byte_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_HDR;
                    if (bus.byte_data != frame_chk(addr_q, data_q)) begin
                        frame_err_s = 1'b1;
                    end else if (addr_q < PAR_MAX_B) begin
                        for (int i = 0; i < CONF_PAR_MAX; i++) begin
                            if (addr_q == 8'(i)) begin
                                shadow_d[i*PAR_W +: PAR_W] = data_q;
                            end else begin
                                shadow_d[i*PAR_W +: PAR_W] = shadow_q[i*PAR_W +: PAR_W];
                            end
                        end
                    end else if (addr_q == COMMIT_ADDR) begin
                        commit_req_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end else begin
            state_d = cur_s;
        end

        if (bus.byte_valid || (cur_s == S_HDR)) begin
            tmo_cnt_d = {CNT_W{1'b0}};
        end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end

        if ((frame_err_s || timeout_s) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        // The copy uses the shadow as registered, so a same-cycle write waits for the next commit.
        if (commit_req_s) begin
            commit_pend_d = 1'b1;
        end else if (do_commit_s) begin
            commit_pend_d = 1'b0;
        end else begin
            commit_pend_d = commit_pend_q;
        end

        if (do_commit_s) begin
            par_out_d   = shadow_q;
            par_valid_d = 1'b1;
        end else begin
            par_out_d   = par_out_q;
            par_valid_d = par_valid_q;
        end
        commit_pls_d = do_commit_s;
        busy_d       = (state_d != S_HDR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_HDR;
            addr_q        <= 8'h00;
            data_q        <= 8'h00;
            shadow_q      <= {BANK_W{1'b0}};
            par_out_q     <= {BANK_W{1'b0}};
            par_valid_q   <= 1'b0;
            commit_pend_q <= 1'b0;
            commit_pls_q  <= 1'b0;
            err_cnt_q     <= 8'h00;
            busy_q        <= 1'b0;
            tmo_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            shadow_q      <= shadow_d;
            par_out_q     <= par_out_d;
            par_valid_q   <= par_valid_d;
            commit_pend_q <= commit_pend_d;
            commit_pls_q  <= commit_pls_d;
            err_cnt_q     <= err_cnt_d;
            busy_q        <= busy_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.par_out     = par_out_q;
    assign bus.par_valid   = par_valid_q;
    assign bus.commit_pend = commit_pend_q;
    assign bus.commit_pls  = commit_pls_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.busy        = busy_q;
endmodule
